tinyalu_arbiter: RTL and testbench
==================================

Name: tinyalu_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the tinyalu datapath.
- Accepts op/A/B requests from two independent requesters and issues one operation at a time on the ALU start/op/A/B bus.
- Waits for done, then returns the 16-bit result to the requester that issued the operation.
- Handles no_op and illegal opcodes locally and recovers from a hung ALU with a timeout.

Parameters:
TIMEOUT_CYCLES, 16, max cycles alu_start may stay high without alu_done before the operation is aborted (legal range 2..255)

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle (valid&&ready)
req0_op  input  3  opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, others illegal
req0_a  input  8  operand A
req0_b  input  8  operand B
rsp0_valid  output  1  one-cycle pulse, response for requester 0
rsp0_result  output  16  result, valid with rsp0_valid
rsp0_err  output  1  illegal op or timeout, valid with rsp0_valid
req1_*/rsp1_*  same widths and meaning as port 0, for requester 1
alu_start  output  1  ALU start
alu_op  output  3  ALU opcode
alu_a  output  8  ALU operand A
alu_b  output  8  ALU operand B
alu_done  input  1  ALU done
alu_result  input  16  ALU result
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, at the clock edge with reset=1): state=IDLE, last_grant=1 (so port 0 wins the first contest), timeout counter=0.
  - Outputs after reset: alu_start=0, alu_op/alu_a/alu_b=0, req*_ready=0, rsp*_valid=0, rsp*_result=0, rsp*_err=0, busy=0.
  - Reset mid-operation aborts it: no response is produced and alu_start is low the cycle after reset.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Grant only when alu_done==0, so a stale done from the previous operation is never reused.
  - Grant rule: if one valid, grant it; if both valid, grant the port != last_grant.
  - req_ready for the granted port is combinational: (state==IDLE && !alu_done && grant==port). At most one ready is high per cycle.
  - On accept: latch op/a/b and the owner id; last_grant=owner.
  - Next state: legal ALU op (001..100) -> ISSUE; no_op -> RESP (result 0, err 0, ALU untouched); illegal op (101..111) -> RESP (result 0, err 1).
- ISSUE:
  - alu_start=1, and alu_op/alu_a/alu_b driven from latched registers, held stable for the whole state.
  - Counter increments every cycle in ISSUE.
  - alu_done==1 sampled: capture alu_result, err=0 -> RESP.
  - Counter reaches TIMEOUT_CYCLES-1 with alu_done==0: result 0, err=1 -> RESP.
  - done and timeout in the same cycle: done wins (err=0, real result).
- RESP:
  - alu_start=0; rsp<owner>_valid=1 for exactly one cycle with the latched result and err; the other port's rsp_valid stays 0.
  - Next cycle -> IDLE; counter cleared.
- Timing:
  - Minimum latency from accept to rsp_valid = 2 cycles plus the ALU's done latency.
  - Accept edge N: alu_start high from N+1. Done sampled at edge M: rsp_valid high during cycle M+1, alu_start low during cycle M+1.
  - no_op/illegal: rsp_valid the cycle after accept.
- Responses have no backpressure; the requester must take the rsp_valid pulse.
- rsp*_result and rsp*_err hold their last value between pulses.
- alu_op/a/b hold their last value outside ISSUE.
- A requester may drop valid before ready without penalty; nothing is latched unless valid&&ready.

Test Plan:
- After reset, port 0 add A=8'h12 B=8'h34, ALU done 1 cycle after start -> alu_start high exactly during ISSUE; rsp0_valid pulse, rsp0_result=16'h0046, err=0; rsp1_valid never high.
- Both ports valid continuously, port0 mul FF*FF, port1 xor F0^0F -> grant order 0,1,0,1; responses 16'hFE01 to port 0 and 16'h00FF to port 1, never swapped.
- Port1 op=3'b110 -> no alu_start; rsp1_valid the cycle after accept with result 0, err=1.
- Port0 no_op -> no alu_start; rsp0_valid next cycle, result 0, err=0; a following add from port 1 still issues normally.
- ALU model never asserts done, TIMEOUT_CYCLES=16 -> alu_start high exactly 16 cycles; rsp_valid with err=1, result 0; next request is serviced.
- Reset asserted 2 cycles into a mul -> alu_start=0 and busy=0 the next cycle; no rsp pulse; next request granted to port 0 first. Also cover done asserted on the same cycle as timeout -> err=0 with the real result.

Source files
------------

// File: rtl/tinyalu_arbiter.sv
// Two-port round-robin front end for the tinyalu datapath: grants one request at a time,
// drives the ALU bus, and returns the result (or an error) to the requester that issued it.
module tinyalu_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_result,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_result,
  output logic        rsp1_err,
  output logic        alu_start,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic        last_grant;
  logic        owner;
  logic [7:0]  cnt;
  logic        grant0, grant1, accept;
  logic [2:0]  sel_op;
  logic [7:0]  sel_a, sel_b;
  logic        op_legal;
  logic        done_now, timeout_now;
  logic        rsp_load, rsp_port, rsp_err_d;
  logic [15:0] rsp_result_d;

  // A stale done left over from the previous operation must never be taken for a new one,
  // so nothing is granted while alu_done is high.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !alu_done && !reset) begin
      grant0 = req0_valid && (!req1_valid || last_grant);
      grant1 = req1_valid && (!req0_valid || !last_grant);
    end
    accept   = grant0 || grant1;
    sel_op   = grant1 ? req1_op : req0_op;
    sel_a    = grant1 ? req1_a  : req0_a;
    sel_b    = grant1 ? req1_b  : req0_b;
    op_legal = (sel_op >= 3'd1) && (sel_op <= 3'd4);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Done wins over a timeout that lands in the same cycle.
  always_comb begin
    done_now     = (state == ISSUE) && alu_done;
    timeout_now  = (state == ISSUE) && !alu_done && (cnt == TIMEOUT_LAST);
    rsp_load     = (accept && !op_legal) || done_now || timeout_now;
    rsp_port     = accept ? grant1 : owner;
    rsp_result_d = done_now ? alu_result : 16'h0000;
    rsp_err_d    = done_now ? 1'b0 : (accept ? (sel_op != 3'd0) : 1'b1);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = op_legal ? ISSUE : RESP;
      ISSUE:   if (done_now || timeout_now) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      cnt         <= 8'd0;
      alu_op      <= 3'd0;
      alu_a       <= 8'd0;
      alu_b       <= 8'd0;
      rsp0_result <= 16'h0000;
      rsp0_err    <= 1'b0;
      rsp1_result <= 16'h0000;
      rsp1_err    <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= (state == ISSUE) ? cnt + 8'd1 : 8'd0;
      if (accept) begin
        owner      <= grant1;
        last_grant <= grant1;
        // The ALU bus only changes for operations that actually reach the ALU.
        if (op_legal) begin
          alu_op <= sel_op;
          alu_a  <= sel_a;
          alu_b  <= sel_b;
        end
      end
      if (rsp_load) begin
        if (rsp_port) begin
          rsp1_result <= rsp_result_d;
          rsp1_err    <= rsp_err_d;
        end else begin
          rsp0_result <= rsp_result_d;
          rsp0_err    <= rsp_err_d;
        end
      end
    end
  end

  assign alu_start  = (state == ISSUE);
  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) && owner;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Self-checking bench for tinyalu_arbiter: vector table for single transactions, a scoreboard
// for every response, and hand-written sequences for round-robin, timeout and reset abort.
module tb_tinyalu_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_err;
  logic [2:0]  req0_op;
  logic [7:0]  req0_a, req0_b;
  logic [15:0] rsp0_result;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_err;
  logic [2:0]  req1_op;
  logic [7:0]  req1_a, req1_b;
  logic [15:0] rsp1_result;
  logic        alu_start, busy;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a, alu_b;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = 16'h0000;

  int n_checks = 0;
  int n_pass   = 0;

  int   alu_lat  = 1;
  bit   alu_hang = 1'b0;
  logic [7:0] alu_cnt = 8'd0;

  typedef struct packed {
    logic        port;
    logic [15:0] res;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        port;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    int          lat;
    bit          hang;
    logic [15:0] res;
    logic        err;
    int          starts;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  tinyalu_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .busy(busy)
  );

  function automatic logic [15:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return 16'(a & b);
      3'd3:    return 16'(a ^ b);
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic exp_t make_exp(input logic port, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.port = port;
    e.res  = 16'h0000;
    e.err  = 1'b0;
    if (op > 3'd4) e.err = 1'b1;
    else if (op != 3'd0) begin
      if (alu_hang || alu_lat + 1 > TIMEOUT) e.err = 1'b1;
      else e.res = alu_model(op, a, b);
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
  endtask

  // ALU responder: one-cycle done pulse alu_lat cycles after start rises, or never when hung.
  always @(posedge clk) begin
    if (!alu_start) begin
      alu_cnt  <= 8'd0;
      alu_done <= 1'b0;
    end else begin
      alu_cnt <= alu_cnt + 8'd1;
      if (!alu_hang && !alu_done && int'(alu_cnt) == alu_lat - 1) begin
        alu_done   <= 1'b1;
        alu_result <= alu_model(alu_op, alu_a, alu_b);
      end else begin
        alu_done <= 1'b0;
      end
    end
  end

  // Scoreboard: expectations pushed on accept, popped on each response pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (req0_valid && req0_ready) sb.push_back(make_exp(1'b0, req0_op, req0_a, req0_b));
      if (req1_valid && req1_ready) sb.push_back(make_exp(1'b1, req1_op, req1_a, req1_b));
      if (rsp0_valid || rsp1_valid) begin
        exp_t e;
        checkOutput("sb_rsp_onehot", 32'(rsp0_valid & rsp1_valid), 32'd0);
        checkOutput("sb_pending", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("sb_port", 32'(rsp1_valid), 32'(e.port));
          checkOutput("sb_result", 32'(rsp1_valid ? rsp1_result : rsp0_result), 32'(e.res));
          checkOutput("sb_err", 32'(rsp1_valid ? rsp1_err : rsp0_err), 32'(e.err));
        end
      end
    end
  end

  task automatic applyStimulus(input logic port, input logic [2:0] op, input logic [7:0] a,
                               input logic [7:0] b, output bit accepted);
    accepted = 1'b0;
    if (port) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else      begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    for (int c = 0; c < 50 && !accepted; c++) begin
      @(negedge clk);
      if (port ? req1_ready : req0_ready) accepted = 1'b1;
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Holds both ports valid until n grants are seen; order[i] is the port granted i-th.
  task automatic runBoth(input int n, output int got, output logic [7:0] order);
    got   = 0;
    order = 8'd0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int c = 0; c < 300 && got < n; c++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        order[got] = req1_ready;
        got++;
      end
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int c = 0;
    while ((sb.size() != 0 || busy) && c < 200) begin
      @(negedge clk);
      c++;
    end
    checkOutput(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit          accepted, got, other;
    int          starts, cyc, ngrant;
    logic [7:0]  order;
    logic [15:0] res;
    logic        err;
    logic [18:0] last_legal;

    vecs[0] = '{1'b0, 3'b001, 8'h12, 8'h34, 1,  1'b0, 16'h0046, 1'b0, 2};
    vecs[1] = '{1'b1, 3'b010, 8'hF0, 8'h3C, 2,  1'b0, 16'h0030, 1'b0, 3};
    vecs[2] = '{1'b0, 3'b011, 8'hAA, 8'h0F, 1,  1'b0, 16'h00A5, 1'b0, 2};
    vecs[3] = '{1'b1, 3'b100, 8'hFF, 8'hFF, 3,  1'b0, 16'hFE01, 1'b0, 4};
    vecs[4] = '{1'b1, 3'b110, 8'h11, 8'h22, 1,  1'b0, 16'h0000, 1'b1, 0};
    vecs[5] = '{1'b0, 3'b000, 8'h33, 8'h44, 1,  1'b0, 16'h0000, 1'b0, 0};
    vecs[6] = '{1'b1, 3'b001, 8'hFF, 8'h01, 1,  1'b0, 16'h0100, 1'b0, 2};
    vecs[7] = '{1'b0, 3'b111, 8'h01, 8'h02, 1,  1'b0, 16'h0000, 1'b1, 0};
    vecs[8] = '{1'b0, 3'b001, 8'h01, 8'h01, 1,  1'b1, 16'h0000, 1'b1, 16};
    vecs[9] = '{1'b1, 3'b100, 8'h10, 8'h10, 15, 1'b0, 16'h0100, 1'b0, 16};

    reset = 1'b1;
    req0_valid = 1'b0; req0_op = 3'd0; req0_a = 8'd0; req0_b = 8'd0;
    req1_valid = 1'b0; req1_op = 3'd0; req1_a = 8'd0; req1_b = 8'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_ctrl", 32'({alu_start, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy}), 32'd0);
    checkOutput("reset_alu_bus", 32'({alu_op, alu_a, alu_b}), 32'd0);
    checkOutput("reset_results", {rsp0_result, rsp1_result}, 32'd0);

    // Round robin with both ports permanently valid, straight after reset.
    @(posedge clk); #1;
    req0_op = 3'b100; req0_a = 8'hFF; req0_b = 8'hFF;
    req1_op = 3'b011; req1_a = 8'hF0; req1_b = 8'h0F;
    alu_lat = 1; alu_hang = 1'b0;
    runBoth(4, ngrant, order);
    checkOutput("rr_grants", 32'(ngrant), 32'd4);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("rr_grant%0d", i), 32'(order[i]), 32'(i % 2));
    drain("rr_drain");

    // Vector table: one transaction at a time.
    last_legal = {3'b100, 8'hFF, 8'hFF};
    for (int i = 0; i < 10; i++) begin
      alu_lat  = vecs[i].lat;
      alu_hang = vecs[i].hang;
      applyStimulus(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, accepted);
      checkOutput($sformatf("v%0d_accept", i), 32'(accepted), 32'd1);
      starts = 0; cyc = 0; got = 1'b0; other = 1'b0; res = 16'h0; err = 1'b0;
      while (!got && cyc < 60) begin
        @(negedge clk);
        cyc++;
        if (alu_start) starts++;
        if (vecs[i].port ? rsp0_valid : rsp1_valid) other = 1'b1;
        if (vecs[i].port ? rsp1_valid : rsp0_valid) begin
          got = 1'b1;
          res = vecs[i].port ? rsp1_result : rsp0_result;
          err = vecs[i].port ? rsp1_err : rsp0_err;
        end
      end
      checkOutput($sformatf("v%0d_rsp_seen", i), 32'(got), 32'd1);
      checkOutput($sformatf("v%0d_result", i), 32'(res), 32'(vecs[i].res));
      checkOutput($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
      checkOutput($sformatf("v%0d_starts", i), 32'(starts), 32'(vecs[i].starts));
      checkOutput($sformatf("v%0d_latency", i), 32'(cyc), 32'(vecs[i].starts + 1));
      checkOutput($sformatf("v%0d_other_port", i), 32'(other), 32'd0);
      if (vecs[i].op == 3'd0 || vecs[i].op > 3'd4)
        checkOutput($sformatf("v%0d_alu_bus_hold", i), 32'({alu_op, alu_a, alu_b}), 32'(last_legal));
      else
        last_legal = {vecs[i].op, vecs[i].a, vecs[i].b};
      @(negedge clk);
      checkOutput($sformatf("v%0d_pulse_end", i), 32'({rsp0_valid, rsp1_valid, busy}), 32'd0);
      @(posedge clk); #1;
    end
    drain("vec_drain");

    // Reset two cycles into a mul aborts it without any response.
    alu_lat = 10; alu_hang = 1'b0;
    applyStimulus(1'b1, 3'b100, 8'h03, 8'h05, accepted);
    checkOutput("abort_accept", 32'(accepted), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    sb.delete();
    @(negedge clk);
    checkOutput("abort_idle", 32'({alu_start, busy}), 32'd0);
    other = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid || alu_start) other = 1'b1;
    end
    checkOutput("abort_quiet", 32'(other), 32'd0);

    // After that reset port 0 must win the first contest.
    @(posedge clk); #1;
    alu_lat = 1;
    req0_op = 3'b001; req0_a = 8'h01; req0_b = 8'h02;
    req1_op = 3'b001; req1_a = 8'h03; req1_b = 8'h04;
    runBoth(2, ngrant, order);
    checkOutput("post_reset_grants", 32'(ngrant), 32'd2);
    checkOutput("post_reset_first", 32'(order[0]), 32'd0);
    checkOutput("post_reset_second", 32'(order[1]), 32'd1);
    drain("post_reset_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
